// File: rtl/udc_pkg.sv
// rtl/udc_pkg.sv - shared constants and range clamp helper for up_down_counter_param
package udc_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Wide enough for any supported WIDTH, so callers just zero-extend and truncate back.
  function automatic logic [63:0] clamp_to_range(input logic [63:0] v,
                                                 input logic [63:0] lo,
                                                 input logic [63:0] hi);
    logic [63:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/udc_next_calc.sv
// rtl/udc_next_calc.sv - combinational next-count and overflow/underflow calculation
module udc_next_calc
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STEP_W  = 2,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              d,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              ovf_n,
  output logic              unf_n
);

  // Two guard bits: one for carry past MAX_VAL, one for sign below MIN_VAL.
  localparam int unsigned AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;
  localparam logic signed [AW-1:0] MIN_S = AW'(MIN_VAL);
  localparam logic signed [AW-1:0] MAX_S = AW'(MAX_VAL);
  localparam logic signed [AW-1:0] R_S   = MAX_S - MIN_S + AW'(1);

  logic signed [AW-1:0] cnt_s;
  logic signed [AW-1:0] stp_s;
  logic signed [AW-1:0] sum_s;
  logic signed [AW-1:0] res_s;

  assign cnt_s = AW'(count);
  assign stp_s = AW'(step);

  always_comb begin
    sum_s = cnt_s;
    res_s = cnt_s;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    case (d)
      DIR_UP: begin
        sum_s = cnt_s + stp_s;
        if (sum_s > MAX_S) begin
          ovf_n = 1'b1;
          res_s = (sat_mode == MODE_WRAP) ? (sum_s - R_S) : MAX_S;
        end else begin
          res_s = sum_s;
        end
      end
      DIR_DOWN: begin
        sum_s = cnt_s - stp_s;
        if (sum_s < MIN_S) begin
          unf_n = 1'b1;
          res_s = (sat_mode == MODE_SAT) ? MIN_S : (sum_s + R_S);
        end else begin
          res_s = sum_s;
        end
      end
    endcase
    next_count = res_s[WIDTH-1:0];
  end

endmodule

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - bounded up/down counter; UDC_STICKY_EN adds sticky ovf/unf flags
module up_down_counter_param
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STEP_W  = 2,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 15,
  parameter int unsigned RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              d,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_min
`ifdef UDC_STICKY_EN
  ,
  input  logic              sticky_clr,
  output logic              ovf_sticky,
  output logic              unf_sticky
`endif
);

  logic [WIDTH-1:0] calc_count;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_d;
  logic             calc_ovf;
  logic             calc_unf;
  logic             ovf_d;
  logic             unf_d;

  udc_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_next_calc (
    .count     (count),
    .step      (step),
    .d         (d),
    .sat_mode  (sat_mode),
    .next_count(calc_count),
    .ovf_n     (calc_ovf),
    .unf_n     (calc_unf)
  );

  assign load_clamped = WIDTH'(clamp_to_range(64'(load_val), 64'(MIN_VAL), 64'(MAX_VAL)));

  always_comb begin
    count_d = count;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = calc_count;
      ovf_d   = calc_ovf;
      unf_d   = calc_unf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= WIDTH'(RST_VAL);
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_d;
      ovf   <= ovf_d;
      unf   <= unf_d;
    end
  end

  assign at_max = (count == WIDTH'(MAX_VAL));
  assign at_min = (count == WIDTH'(MIN_VAL));

`ifdef UDC_STICKY_EN
  // Set takes precedence over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_d | (ovf_sticky & ~sticky_clr);
      unf_sticky <= unf_d | (unf_sticky & ~sticky_clr);
    end
  end
`endif

  step_in_range: assert property (@(posedge clk) disable iff (rst)
    (en && !load) |-> (64'(step) <= (64'(MAX_VAL) - 64'(MIN_VAL) + 64'd1)));

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - self-checking bench for up_down_counter_param (two range configurations)
module tb_up_down_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       d;
  logic       sat_mode;
  logic [1:0] step;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count_a, count_b;
  logic       ovf_a, unf_a, at_max_a, at_min_a;
  logic       ovf_b, unf_b, at_max_b, at_min_b;
`ifdef UDC_STICKY_EN
  logic       sticky_clr;
  logic       ovf_sticky_a, unf_sticky_a, ovf_sticky_b, unf_sticky_b;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: A covers [0,9] reset 0, B covers [2,12] reset 5.
  int mcnt_a, mcnt_b;
  bit mo_a, mu_a, mo_b, mu_b;

  always #5 clk = ~clk;

  up_down_counter_param #(.WIDTH(4), .STEP_W(2), .MIN_VAL(0), .MAX_VAL(9), .RST_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .d(d), .sat_mode(sat_mode), .step(step),
    .load(load), .load_val(load_val), .count(count_a), .ovf(ovf_a), .unf(unf_a),
    .at_max(at_max_a), .at_min(at_min_a)
`ifdef UDC_STICKY_EN
    , .sticky_clr(sticky_clr), .ovf_sticky(ovf_sticky_a), .unf_sticky(unf_sticky_a)
`endif
  );

  up_down_counter_param #(.WIDTH(4), .STEP_W(2), .MIN_VAL(2), .MAX_VAL(12), .RST_VAL(5)) dut_b (
    .clk(clk), .rst(rst), .en(en), .d(d), .sat_mode(sat_mode), .step(step),
    .load(load), .load_val(load_val), .count(count_b), .ovf(ovf_b), .unf(unf_b),
    .at_max(at_max_b), .at_min(at_min_b)
`ifdef UDC_STICKY_EN
    , .sticky_clr(sticky_clr), .ovf_sticky(ovf_sticky_b), .unf_sticky(unf_sticky_b)
`endif
  );

  function automatic void ref_next(input int mn, input int mx, input int c,
                                   input bit ld, input int lv, input bit e,
                                   input bit up, input bit sat, input int st,
                                   output int nc, output bit o, output bit u);
    int r;
    int n;
    r  = mx - mn + 1;
    nc = c;
    o  = 0;
    u  = 0;
    if (ld) begin
      nc = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
    end else if (e) begin
      n = up ? c + st : c - st;
      if (n > mx) begin
        o  = 1;
        nc = sat ? mx : n - r;
      end else if (n < mn) begin
        u  = 1;
        nc = sat ? mn : n + r;
      end else begin
        nc = n;
      end
    end
  endfunction

  task automatic cycle();
    int na, nb;
    bit oa, ua, ob, ub;
    ref_next(0, 9, mcnt_a, load, int'(load_val), en, d, sat_mode, int'(step), na, oa, ua);
    ref_next(2, 12, mcnt_b, load, int'(load_val), en, d, sat_mode, int'(step), nb, ob, ub);
    @(posedge clk);
    #1;
    mcnt_a = na; mo_a = oa; mu_a = ua;
    mcnt_b = nb; mo_b = ob; mu_b = ub;
  endtask

  task automatic do_load(input int v);
    load = 1; en = 0; load_val = 4'(v);
    cycle();
    load = 0;
  endtask

  task automatic test_reset();
    checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL reset_count_a got %0d expected 0", count_a); end
    checks++; if (count_b !== 4'd5) begin errors++; $display("FAIL reset_count_b got %0d expected 5", count_b); end
    checks++; if ({ovf_a, unf_a, ovf_b, unf_b} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b expected 0000", {ovf_a, unf_a, ovf_b, unf_b}); end
    do_load(9);
    en = 1; d = 1; step = 2'd1; sat_mode = 0;
    checks++; if (count_a !== 4'd9) begin errors++; $display("FAIL reset_preload got %0d expected 9", count_a); end
    #2 rst = 1;
    #1;
    checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL reset_async_count got %0d expected 0", count_a); end
    checks++; if ({ovf_a, unf_a} !== 2'b00) begin errors++; $display("FAIL reset_async_flags got %b expected 00", {ovf_a, unf_a}); end
    @(posedge clk);
    #1;
    rst = 0; en = 0;
    mcnt_a = 0; mcnt_b = 5; mo_a = 0; mu_a = 0; mo_b = 0; mu_b = 0;
    cycle();
    checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL reset_hold got %0d expected 0", count_a); end
    checks++; if (at_min_a !== 1'b1) begin errors++; $display("FAIL reset_at_min got %b expected 1", at_min_a); end
  endtask

  task automatic test_wrap_up();
    int exp_c[5] = '{3, 6, 9, 2, 5};
    bit exp_o[5] = '{0, 0, 0, 1, 0};
    do_load(0);
    en = 1; d = 1; step = 2'd3; sat_mode = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (count_a !== 4'(exp_c[i])) begin errors++; $display("FAIL wrap_count[%0d] got %0d expected %0d", i, count_a, exp_c[i]); end
      checks++; if (ovf_a !== exp_o[i]) begin errors++; $display("FAIL wrap_ovf[%0d] got %b expected %b", i, ovf_a, exp_o[i]); end
      checks++; if (at_max_a !== (exp_c[i] == 9)) begin errors++; $display("FAIL wrap_at_max[%0d] got %b expected %b", i, at_max_a, exp_c[i] == 9); end
    end
    en = 0;
  endtask

  task automatic test_saturate_down();
    int exp_c[4] = '{3, 2, 2, 2};
    bit exp_u[4] = '{0, 1, 1, 0};
    do_load(5);
    en = 1; d = 0; step = 2'd2; sat_mode = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) step = 2'd0;
      cycle();
      checks++; if (count_b !== 4'(exp_c[i])) begin errors++; $display("FAIL sat_count[%0d] got %0d expected %0d", i, count_b, exp_c[i]); end
      checks++; if (unf_b !== exp_u[i]) begin errors++; $display("FAIL sat_unf[%0d] got %b expected %b", i, unf_b, exp_u[i]); end
      checks++; if (at_min_b !== (exp_c[i] == 2)) begin errors++; $display("FAIL sat_at_min[%0d] got %b expected %b", i, at_min_b, exp_c[i] == 2); end
    end
    en = 0;
  endtask

  task automatic test_load_priority();
    load = 1; en = 1; load_val = 4'd14; d = 1; step = 2'd1; sat_mode = 0;
    cycle();
    load = 0;
    checks++; if (count_b !== 4'd12) begin errors++; $display("FAIL load_clamp_b got %0d expected 12", count_b); end
    checks++; if (count_a !== 4'd9) begin errors++; $display("FAIL load_clamp_a got %0d expected 9", count_a); end
    checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL load_ovf got %b expected 0", ovf_b); end
    cycle();
    checks++; if (count_b !== 4'd2) begin errors++; $display("FAIL load_wrap_b got %0d expected 2", count_b); end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL load_wrap_ovf got %b expected 1", ovf_b); end
    checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL load_wrap_a got %0d expected 0", count_a); end
    en = 0;
  endtask

  task automatic test_direction_toggle();
    int exp_c[4] = '{5, 4, 5, 4};
    do_load(4);
    en = 1; step = 2'd1; sat_mode = 0;
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0);
      cycle();
      checks++; if (count_a !== 4'(exp_c[i])) begin errors++; $display("FAIL toggle_count[%0d] got %0d expected %0d", i, count_a, exp_c[i]); end
      checks++; if ({ovf_a, unf_a} !== 2'b00) begin errors++; $display("FAIL toggle_flags[%0d] got %b expected 00", i, {ovf_a, unf_a}); end
    end
    en = 0;
  endtask

`ifdef UDC_STICKY_EN
  task automatic test_sticky();
    do_load(9);
    sticky_clr = 1; en = 0;
    cycle();
    checks++; if ({ovf_sticky_a, unf_sticky_a} !== 2'b00) begin errors++; $display("FAIL sticky_cleared got %b expected 00", {ovf_sticky_a, unf_sticky_a}); end
    sticky_clr = 0; en = 1; d = 1; step = 2'd1; sat_mode = 1;
    cycle();
    checks++; if (ovf_sticky_a !== 1'b1) begin errors++; $display("FAIL sticky_set got %b expected 1", ovf_sticky_a); end
    sticky_clr = 1;
    cycle();
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL sticky_reovf got %b expected 1", ovf_a); end
    checks++; if (ovf_sticky_a !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %b expected 1", ovf_sticky_a); end
    en = 0;
    cycle();
    checks++; if (ovf_sticky_a !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b expected 0", ovf_sticky_a); end
    sticky_clr = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      d        = 1'($urandom_range(0, 1));
      sat_mode = 1'($urandom_range(0, 1));
      step     = 2'($urandom_range(0, 3));
      cycle();
      checks++; if (count_a !== 4'(mcnt_a) || ovf_a !== mo_a || unf_a !== mu_a) begin errors++; $display("FAIL rand_a[%0d] got %0d/%b/%b expected %0d/%b/%b", i, count_a, ovf_a, unf_a, mcnt_a, mo_a, mu_a); end
      checks++; if (count_b !== 4'(mcnt_b) || ovf_b !== mo_b || unf_b !== mu_b) begin errors++; $display("FAIL rand_b[%0d] got %0d/%b/%b expected %0d/%b/%b", i, count_b, ovf_b, unf_b, mcnt_b, mo_b, mu_b); end
      checks++; if ({at_max_a, at_min_a, at_max_b, at_min_b} !== {mcnt_a == 9, mcnt_a == 0, mcnt_b == 12, mcnt_b == 2}) begin errors++; $display("FAIL rand_bounds[%0d] got %b expected %b", i, {at_max_a, at_min_a, at_max_b, at_min_b}, {mcnt_a == 9, mcnt_a == 0, mcnt_b == 12, mcnt_b == 2}); end
    end
    load = 0; en = 0;
  endtask

  initial begin
    rst = 1; en = 0; d = 0; sat_mode = 0; step = 2'd0; load = 0; load_val = 4'd0;
`ifdef UDC_STICKY_EN
    sticky_clr = 0;
`endif
    mcnt_a = 0; mcnt_b = 5; mo_a = 0; mu_a = 0; mo_b = 0; mu_b = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_wrap_up();
    test_saturate_down();
    test_load_priority();
    test_direction_toggle();
`ifdef UDC_STICKY_EN
    test_sticky();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
